// File: rtl/niox_bd_seq.sv
// rtl/niox_bd_seq.sv - autonomous command sequencer for the niox bd port
// Optional watchdog abort of stalled wait states: define NIOX_BD_TIMEOUT_EN.
module niox_bd_seq #(
  parameter int WORDS   = 256,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_cmd,
  input  logic [23:0] req_addr,
  input  logic        req_start,
  output logic        req_busy,
  output logic        req_done,
  output logic        req_err,
  output logic [15:0] rd_word,
  output logic        rd_strobe,
  input  logic [15:0] wr_word,
  input  logic        wr_valid,
  output logic        wr_ack,
  output logic [1:0]  bd_cmd,
  output logic        bd_start,
  input  logic        bd_bsy,
  input  logic        bd_rdy,
  input  logic        bd_err,
  output logic [23:0] bd_addr,
  input  logic [15:0] bd_data_in,
  output logic [15:0] bd_data_out,
  output logic        bd_rd,
  output logic        bd_wr,
  input  logic        bd_iordy
);

  localparam int CW = $clog2(WORDS) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT_BSY, S_RD_WAIT, S_RD_STB, S_RD_CAP,
    S_WR_WAIT, S_WR_STB, S_FIN_WAIT, S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, err_q, rd_stb_q;
  logic          bd_start_q, bd_rd_q, bd_wr_q;
  logic [1:0]    cmd_q;
  logic [23:0]   addr_q;
  logic [15:0]   rd_word_q, wr_data_q;
  logic          wd_hit, last_word, abort;

`ifdef NIOX_BD_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q;
  logic          in_wait;

  assign in_wait = state_q inside {S_START, S_RD_WAIT, S_WR_WAIT, S_FIN_WAIT};

  // Every path into a wait state passes through a non-wait state, so
  // clearing outside wait states restarts the count on each state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (in_wait) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  assign wd_hit = in_wait && (wd_q == WW'(TIMEOUT - 1));
`else
  assign wd_hit = 1'b0 & (TIMEOUT != 0);
`endif

  assign last_word = (cnt_q == CW'(WORDS - 1));
  assign abort     = (state_q != S_IDLE) && (state_q != S_DONE) && (bd_err || wd_hit);
  assign wr_ack    = (state_q == S_WR_WAIT) && wr_valid && bd_iordy && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_stb_q   <= 1'b0;
      bd_start_q <= 1'b0;
      bd_rd_q    <= 1'b0;
      bd_wr_q    <= 1'b0;
      cmd_q      <= 2'd0;
      addr_q     <= 24'd0;
      rd_word_q  <= 16'd0;
      wr_data_q  <= 16'd0;
    end else begin
      done_q   <= 1'b0;
      rd_stb_q <= 1'b0;
      bd_rd_q  <= 1'b0;
      bd_wr_q  <= 1'b0;
      if (abort) begin
        // bd_err outranks iordy/rdy; partial word count is simply abandoned
        err_q      <= 1'b1;
        bd_start_q <= 1'b0;
        done_q     <= 1'b1;
        state_q    <= S_DONE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req_start) begin
              cmd_q      <= req_cmd;
              addr_q     <= req_addr;
              cnt_q      <= '0;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              bd_start_q <= 1'b1;
              state_q    <= S_START;
            end
          end
          S_START: begin
            if (bd_bsy) begin
              bd_start_q <= 1'b0;
              state_q    <= S_WAIT_BSY;
            end
          end
          S_WAIT_BSY: begin
            case (cmd_q)
              2'd1:    state_q <= S_RD_WAIT;
              2'd2:    state_q <= S_WR_WAIT;
              default: state_q <= S_FIN_WAIT;
            endcase
          end
          S_RD_WAIT: begin
            if (bd_iordy) begin
              bd_rd_q <= 1'b1;
              state_q <= S_RD_STB;
            end
          end
          S_RD_STB: state_q <= S_RD_CAP;
          S_RD_CAP: begin
            rd_word_q <= bd_data_in;
            rd_stb_q  <= 1'b1;
            cnt_q     <= cnt_q + 1'b1;
            state_q   <= last_word ? S_FIN_WAIT : S_RD_WAIT;
          end
          S_WR_WAIT: begin
            if (wr_valid && bd_iordy) begin
              wr_data_q <= wr_word;
              bd_wr_q   <= 1'b1;
              state_q   <= S_WR_STB;
            end
          end
          S_WR_STB: begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= last_word ? S_FIN_WAIT : S_WR_WAIT;
          end
          S_FIN_WAIT: begin
            if (!bd_bsy && bd_rdy) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign req_busy    = busy_q;
  assign req_done    = done_q;
  assign req_err     = err_q;
  assign rd_word     = rd_word_q;
  assign rd_strobe   = rd_stb_q;
  assign bd_cmd      = cmd_q;
  assign bd_start    = bd_start_q;
  assign bd_addr     = addr_q;
  assign bd_data_out = wr_data_q;
  assign bd_rd       = bd_rd_q;
  assign bd_wr       = bd_wr_q;

endmodule

// File: tb/tb_niox_bd_seq.sv
// tb/tb_niox_bd_seq.sv - self-checking bench for niox_bd_seq
// Honours NIOX_BD_TIMEOUT_EN for the watchdog expectations.
module tb_niox_bd_seq;
  localparam int WORDS   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_cmd = 2'd0;
  logic [23:0] req_addr = 24'd0;
  logic        req_start = 1'b0;
  logic        req_busy, req_done, req_err;
  logic [15:0] rd_word;
  logic        rd_strobe;
  logic [15:0] wr_word = 16'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ack;
  logic [1:0]  bd_cmd;
  logic        bd_start;
  logic        bd_bsy = 1'b0, bd_rdy = 1'b1, bd_err = 1'b0, bd_iordy = 1'b0;
  logic [23:0] bd_addr;
  logic [15:0] bd_data_in = 16'd0;
  logic [15:0] bd_data_out;
  logic        bd_rd, bd_wr;

  niox_bd_seq #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_start(req_start),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
    .rd_word(rd_word), .rd_strobe(rd_strobe),
    .wr_word(wr_word), .wr_valid(wr_valid), .wr_ack(wr_ack),
    .bd_cmd(bd_cmd), .bd_start(bd_start), .bd_bsy(bd_bsy), .bd_rdy(bd_rdy),
    .bd_err(bd_err), .bd_addr(bd_addr), .bd_data_in(bd_data_in),
    .bd_data_out(bd_data_out), .bd_rd(bd_rd), .bd_wr(bd_wr), .bd_iordy(bd_iordy)
  );

  always #5 clk = ~clk;

  logic [65:0] outs;
  assign outs = {req_busy, req_done, req_err, rd_word, rd_strobe, wr_ack, bd_cmd,
                 bd_start, bd_addr, bd_data_out, bd_rd, bd_wr};

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [15:0] rd_src [16];
  logic [15:0] wr_src [16];
  int rd_pulses, wr_pulses, strobes, acks, dones, rd_chk_i, wr_chk_i;
  int need, ops, rd_idx, wr_idx, wr_n, err_after, errw, fin_dly, fin_cnt;
  logic bsy_en = 1'b1, m_busy = 1'b0, gap_mode = 1'b0, rnd_iordy = 1'b0, ph = 1'b0;
  logic ack_seen = 1'b0;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: word order against the source tables, pulse bookkeeping
  always @(negedge clk) begin
    if (bd_rd || bd_wr) chk("strobe_exclusive", bd_rd && bd_wr, 1'b0);
    if (bd_rd) rd_pulses++;
    if (bd_wr) begin
      wr_pulses++;
      chk("bd_data_out", bd_data_out, wr_src[wr_chk_i % 16]);
      wr_chk_i++;
    end
    if (rd_strobe) begin
      strobes++;
      chk("rd_word", rd_word, rd_src[rd_chk_i % 16]);
      rd_chk_i++;
    end
    if (wr_ack) begin
      acks++;
      ack_seen = 1'b1;
      chk("ack_needs_valid_iordy", wr_valid & bd_iordy, 1'b1);
    end
    if (req_done) dones++;
  end

  // bd core model and write producer
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      bd_bsy = 1'b0; bd_rdy = 1'b1; bd_err = 1'b0; bd_iordy = 1'b0;
      wr_valid = 1'b0; m_busy = 1'b0; ack_seen = 1'b0;
    end else begin
      bd_err = 1'b0;
      if (ack_seen) begin wr_idx++; ack_seen = 1'b0; end
      if (bd_rd) begin bd_data_in = rd_src[rd_idx % 16]; rd_idx++; ops++; end
      if (bd_wr) ops++;
      if (m_busy && err_after > 0 && ops >= err_after) begin
        errw++;
        if (errw == 3) begin
          bd_err = 1'b1; bd_bsy = 1'b0; bd_rdy = 1'b1; m_busy = 1'b0; err_after = 0;
        end
      end else if (m_busy && ops >= need) begin
        if (fin_cnt == 0) begin bd_bsy = 1'b0; bd_rdy = 1'b1; m_busy = 1'b0; end
        else fin_cnt--;
      end else if (!m_busy && bsy_en && bd_start) begin
        m_busy = 1'b1; bd_bsy = 1'b1; bd_rdy = 1'b0; fin_cnt = fin_dly;
      end
      bd_iordy = m_busy && (ops < need) && !(err_after > 0 && ops >= err_after) &&
                 (!rnd_iordy || ($urandom % 4 != 0));
      if (wr_idx < wr_n) begin
        ph = ~ph;
        wr_valid = gap_mode ? ph : ($urandom % 2 == 1);
        wr_word = wr_src[wr_idx % 16];
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic prep(input int nd, input int nwr);
    ops = 0; rd_idx = 0; wr_idx = 0; rd_chk_i = 0; wr_chk_i = 0;
    rd_pulses = 0; wr_pulses = 0; strobes = 0; acks = 0; dones = 0;
    need = nd; wr_n = nwr; errw = 0; err_after = 0; ph = 1'b0;
  endtask

  task automatic start_cmd(input logic [1:0] c, input logic [23:0] a);
    req_cmd = c; req_addr = a; req_start = 1'b1;
    tick();
    req_start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag, output logic e, output int at);
    bit seen;
    seen = 1'b0; e = 1'bx; at = -1;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (req_done) begin seen = 1'b1; e = req_err; at = cyc; end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic e;
    int at, c0, d0;
    logic [1:0] c;
    logic [23:0] a;

    fin_dly = 1;
    prep(0, 0);
    repeat (3) tick();
    chk("reset_outputs", outs, 66'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_not_busy", req_busy, 1'b0);

    // directed read A001..A004
    for (int i = 0; i < 16; i++) rd_src[i] = 16'hA001 + 16'(i);
    prep(WORDS, 0); rnd_iordy = 1'b0; bsy_en = 1'b1;
    start_cmd(2'd1, 24'h000123);
    chk("rd_bd_addr", bd_addr, 24'h000123);
    chk("rd_bd_cmd", bd_cmd, 2'd1);
    chk("rd_busy", req_busy, 1'b1);
    wait_done(200, "rd", e, at);
    chk("rd_err", e, 1'b0);
    tick();
    chk("rd_busy_after", req_busy, 1'b0);
    chk("rd_pulses", rd_pulses, WORDS);
    chk("rd_strobes", strobes, WORDS);
    chk("rd_dones", dones, 1);

    // directed write 5000..5003, producer valid every other cycle
    for (int i = 0; i < 16; i++) wr_src[i] = 16'h5000 + 16'(i);
    prep(WORDS, WORDS); gap_mode = 1'b1;
    start_cmd(2'd2, 24'h00ABCD);
    wait_done(200, "wr", e, at);
    chk("wr_err", e, 1'b0);
    tick();
    chk("wr_acks", acks, WORDS);
    chk("wr_pulses", wr_pulses, WORDS);
    chk("wr_no_rd", rd_pulses, 0);
    chk("wr_dones", dones, 1);
    gap_mode = 1'b0;

    // randomized reads and writes
    for (int r = 0; r < 4; r++) begin
      c = (r % 2 == 1) ? 2'd2 : 2'd1;
      a = 24'($urandom);
      for (int i = 0; i < 16; i++) begin
        rd_src[i] = 16'($urandom);
        wr_src[i] = 16'($urandom);
      end
      prep(WORDS, (c == 2'd2) ? WORDS : 0);
      rnd_iordy = 1'b1; fin_dly = int'($urandom % 4);
      start_cmd(c, a);
      chk("rnd_addr", bd_addr, a);
      wait_done(400, "rnd", e, at);
      chk("rnd_err", e, 1'b0);
      tick();
      chk("rnd_rd_pulses", rd_pulses, (c == 2'd1) ? WORDS : 0);
      chk("rnd_wr_pulses", wr_pulses, (c == 2'd2) ? WORDS : 0);
      chk("rnd_strobes_acks", strobes + acks, WORDS);
    end

    // status, with a second start while busy
    prep(0, 0); rnd_iordy = 1'b0; fin_dly = 5;
    start_cmd(2'd3, 24'h0F0F0F);
    tick();
    req_cmd = 2'd1; req_addr = 24'h111111; req_start = 1'b1;
    tick();
    req_start = 1'b0;
    chk("busy_start_cmd_kept", bd_cmd, 2'd3);
    chk("busy_start_addr_kept", bd_addr, 24'h0F0F0F);
    wait_done(100, "st", e, at);
    chk("st_err", e, 1'b0);
    repeat (10) tick();
    chk("st_single_done", dones, 1);
    chk("st_no_strobes", rd_pulses + wr_pulses, 0);
    fin_dly = 1;

    // bd_err after the second read word
    for (int i = 0; i < 16; i++) rd_src[i] = 16'($urandom);
    prep(WORDS, 0); err_after = 2;
    start_cmd(2'd1, 24'h000200);
    wait_done(200, "er", e, at);
    chk("er_err", e, 1'b1);
    chk("er_rd_pulses", rd_pulses, 2);
    chk("er_strobes", strobes, 2);
    repeat (5) tick();
    chk("er_err_held", req_err, 1'b1);
    chk("er_not_busy", req_busy, 1'b0);
    chk("er_dones", dones, 1);

    // reset in the middle of a write
    for (int i = 0; i < 16; i++) wr_src[i] = 16'($urandom);
    prep(WORDS, WORDS);
    start_cmd(2'd2, 24'h000300);
    chk("start_clears_err", req_err, 1'b0);
    for (int i = 0; i < 200 && wr_pulses < 2; i++) tick();
    chk("mid_wr_pulses", wr_pulses, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs, 66'd0);
    d0 = dones;
    repeat (3) tick();
    chk("reset_no_done", dones, d0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) rd_src[i] = 16'($urandom);
    prep(WORDS, 0);
    start_cmd(2'd1, 24'h000301);
    wait_done(200, "post_rst", e, at);
    chk("post_rst_err", e, 1'b0);
    tick();
    chk("post_rst_strobes", strobes, WORDS);

    // bd_bsy never asserted
    prep(0, 0); bsy_en = 1'b0;
    start_cmd(2'd3, 24'h000400);
    c0 = cyc;
    chk("to_start_high", bd_start, 1'b1);
`ifdef NIOX_BD_TIMEOUT_EN
    wait_done(40, "to", e, at);
    chk("to_err", e, 1'b1);
    chk("to_latency", at - c0, TIMEOUT);
    chk("to_start_low", bd_start, 1'b0);
`else
    repeat (1000) tick();
    chk("nto_still_busy", req_busy, 1'b1);
    chk("nto_no_done", dones, 0);
    chk("nto_start_held", bd_start, 1'b1);
    bsy_en = 1'b1;
    wait_done(100, "nto", e, at);
    chk("nto_err", e, 1'b0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
